// File: rtl/comparator_pkg.sv
// Shared codes, state type and one-hot check for the comparator monitor.
package comparator_pkg;

    localparam logic [2:0] CMP_GREATER = 3'b100;
    localparam logic [2:0] CMP_EQUAL   = 3'b010;
    localparam logic [2:0] CMP_LESS    = 3'b001;

    typedef enum logic {
        IDLE,
        FILTER
    } state_t;

    function automatic logic is_valid_code(input logic [2:0] code);
        return (code == CMP_GREATER) || (code == CMP_EQUAL) || (code == CMP_LESS);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/comparator_monitor.sv
// Debounces the comparator's one-hot result, commits stable values and
// keeps per-category commit counts plus a sticky invalid-code flag.
module comparator_monitor
    import comparator_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [2:0]             xyz_in,
    input  logic                   clear,
    output logic [2:0]             result,
    output logic                   result_valid,
    output logic                   change_pulse,
    output logic [COUNT_WIDTH-1:0] count_greater,
    output logic [COUNT_WIDTH-1:0] count_equal,
    output logic [COUNT_WIDTH-1:0] count_less,
    output logic                   invalid_flag
);

    localparam int unsigned    FW   = $clog2(STABLE_CYCLES) + 1;
    localparam logic [FW-1:0]  LAST = FW'(STABLE_CYCLES - 1);

    state_t        state, next_state;
    logic [2:0]    sample;
    logic [2:0]    candidate;
    logic [FW-1:0] filt_cnt;
    logic          primed;
    logic          sample_ok;
    logic          bad_sample;
    logic          load;
    logic          advance;
    logic          commit;

    assign sample_ok  = is_valid_code(sample);
    // The reset value of sample was never seen on xyz_in, so it is ignored
    // until the first real sample has been registered.
    assign bad_sample = primed && !sample_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (primed && sample_ok && (sample != result)) begin
                    next_state = FILTER;
                end
            end
            FILTER: begin
                if (sample == candidate) begin
                    if (filt_cnt == LAST) begin
                        next_state = IDLE;
                    end
                end else if (!sample_ok || (sample == result)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        advance = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                load = primed && sample_ok && (sample != result);
            end
            FILTER: begin
                if (sample == candidate) begin
                    commit  = (filt_cnt == LAST);
                    advance = (filt_cnt != LAST);
                end else if (sample_ok && (sample != result)) begin
                    load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample       <= '0;
            primed       <= 1'b0;
            candidate    <= '0;
            filt_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            change_pulse <= 1'b0;
            invalid_flag <= 1'b0;
        end else begin
            sample       <= xyz_in;
            primed       <= 1'b1;
            change_pulse <= commit;
            if (load) begin
                candidate <= sample;
                filt_cnt  <= FW'(1);
            end else if (advance) begin
                filt_cnt <= filt_cnt + FW'(1);
            end
            if (commit) begin
                result       <= candidate;
                result_valid <= 1'b1;
            end
            if (bad_sample) begin
                invalid_flag <= 1'b1;
            end else if (clear) begin
                invalid_flag <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_greater (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (commit && (candidate == CMP_GREATER)),
        .count   (count_greater)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_equal (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (commit && (candidate == CMP_EQUAL)),
        .count   (count_equal)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_less (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (commit && (candidate == CMP_LESS)),
        .count   (count_less)
    );

endmodule

// File: tb/tb_comparator_monitor.sv
// Bench for comparator_monitor: run-length reference model checked every
// cycle, directed scenarios with literal expectations, then random runs.
module tb_comparator_monitor;

    localparam int SC = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          clear = 1'b0;
    logic [2:0]    xyz_in = 3'b000;
    logic [2:0]    result;
    logic          result_valid;
    logic          change_pulse;
    logic [CW-1:0] count_greater;
    logic [CW-1:0] count_equal;
    logic [CW-1:0] count_less;
    logic          invalid_flag;

    int checks = 0;
    int fails = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    comparator_monitor #(
        .STABLE_CYCLES (SC),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .xyz_in        (xyz_in),
        .clear         (clear),
        .result        (result),
        .result_valid  (result_valid),
        .change_pulse  (change_pulse),
        .count_greater (count_greater),
        .count_equal   (count_equal),
        .count_less    (count_less),
        .invalid_flag  (invalid_flag)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a value commits when it has been seen for exactly
    // SC consecutive samples, is one-hot and differs from the current result.
    logic [2:0] m_sample, m_prev, m_result, s;
    bit         m_primed, m_valid, m_pulse, m_inv, bad, commit;
    int         m_run;
    int         m_cnt[3];
    int         idx;

    function automatic int cat(input logic [2:0] c);
        return (c == 3'b100) ? 0 : (c == 3'b010) ? 1 : 2;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_sample = 3'b000; m_prev = 3'b000; m_result = 3'b000;
            m_primed = 0; m_valid = 0; m_pulse = 0; m_inv = 0; m_run = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else begin
            commit = 0;
            bad = 0;
            if (m_primed) begin
                s = m_sample;
                if (m_run > 0 && s == m_prev) begin
                    if (m_run <= SC) m_run++;
                end else begin
                    m_run = 1;
                end
                m_prev = s;
                bad = ($countones(s) != 1);
                commit = !bad && (s != m_result) && (m_run == SC);
            end
            m_pulse = commit;
            if (commit) begin
                m_result = s;
                m_valid = 1;
            end
            for (int i = 0; i < 3; i++) begin
                if (clear) m_cnt[i] = 0;
                else if (commit && cat(s) == i && m_cnt[i] < CMAX) m_cnt[i]++;
            end
            if (bad) m_inv = 1;
            else if (clear) m_inv = 0;
            m_sample = xyz_in;
            m_primed = 1;
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            chk("result", result, m_result);
            chk("result_valid", result_valid, m_valid);
            chk("change_pulse", change_pulse, m_pulse);
            chk("count_greater", count_greater, m_cnt[0]);
            chk("count_equal", count_equal, m_cnt[1]);
            chk("count_less", count_less, m_cnt[2]);
            chk("invalid_flag", invalid_flag, m_inv);
        end
    end

    task automatic hold(input logic [2:0] v, input int n);
        xyz_in = v;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        check_en = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        hold(3'b010, 6);
        chk("lit_first_equal", result, 3'b010);

        // Asynchronous reset mid-cycle
        xyz_in = 3'b100;
        #2 reset_n = 1'b0;
        #1;
        chk("lit_async_result", result, 0);
        chk("lit_async_valid", result_valid, 0);
        chk("lit_async_count_equal", count_equal, 0);
        @(negedge clock);
        reset_n = 1'b1;
        hold(3'b100, 4);
        chk("lit_pre_commit_result", result, 0);
        @(negedge clock);
        chk("lit_commit_result", result, 3'b100);
        chk("lit_commit_pulse", change_pulse, 1);
        chk("lit_commit_count_greater", count_greater, 1);
        chk("lit_no_invalid_after_reset", invalid_flag, 0);
        @(negedge clock);
        chk("lit_pulse_single", change_pulse, 0);

        // Glitch rejection
        hold(3'b010, 6);
        hold(3'b001, 3);
        hold(3'b010, 6);
        chk("lit_glitch_result", result, 3'b010);
        chk("lit_glitch_count_less", count_less, 0);

        // Candidate restart
        hold(3'b001, 2);
        hold(3'b100, 4);
        chk("lit_restart_before", result, 3'b010);
        @(negedge clock);
        chk("lit_restart_result", result, 3'b100);
        chk("lit_restart_pulse", change_pulse, 1);
        chk("lit_restart_count_less", count_less, 0);
        hold(3'b100, 2);

        // Saturation
        for (int i = 0; i < 40; i++) hold((i % 2 == 0) ? 3'b010 : 3'b100, 6);
        chk("lit_sat_greater", count_greater, 15);
        chk("lit_sat_equal", count_equal, 15);

        // Invalid code during FILTER, then clear
        hold(3'b010, 2);
        hold(3'b011, 1);
        hold(3'b100, 3);
        chk("lit_invalid_flag", invalid_flag, 1);
        chk("lit_invalid_result", result, 3'b100);
        repeat (5) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("lit_clear_flag", invalid_flag, 0);
        chk("lit_clear_greater", count_greater, 0);
        chk("lit_clear_equal", count_equal, 0);
        chk("lit_clear_keeps_result", result, 3'b100);
        chk("lit_clear_keeps_valid", result_valid, 1);

        // Clear on the commit edge
        hold(3'b010, 4);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("lit_clrcommit_result", result, 3'b010);
        chk("lit_clrcommit_pulse", change_pulse, 1);
        chk("lit_clrcommit_count", count_equal, 0);
        hold(3'b010, 2);

        // Random runs of codes with occasional invalid codes and clears
        for (int r = 0; r < 150; r++) begin
            logic [2:0] v;
            int len;
            if ($urandom_range(0, 99) < 85) begin
                case ($urandom_range(0, 2))
                    0: v = 3'b100;
                    1: v = 3'b010;
                    default: v = 3'b001;
                endcase
            end else begin
                v = 3'($urandom_range(0, 7));
            end
            len = $urandom_range(1, 7);
            xyz_in = v;
            for (int c = 0; c < len; c++) begin
                clear = ($urandom_range(0, 15) == 0);
                @(negedge clock);
            end
            clear = 1'b0;
        end
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
